// File: rtl/di_xfw_bypass_if.sv
// Operand-forwarding bus between the decode/issue stages and the bypass unit.
// The master side drives writes and read requests; the slave side returns hits and counters.
interface di_xfw_bypass_if #(
    parameter int unsigned N_ISSUE = 2,
    parameter int unsigned N_RD    = 4,
    parameter int unsigned CNT_W   = 32
);
    logic [N_ISSUE-1:0]    alu_we_fw_i;
    logic [6*N_ISSUE-1:0]  alu_waddr_fw_i;
    logic [32*N_ISSUE-1:0] alu_wdata_fw_i;
    logic [N_ISSUE-1:0]    ex_ld_pend_i;
    logic [6*N_ISSUE-1:0]  waddr_ex_i;
    logic [N_ISSUE-1:0]    we_wb_i;
    logic [6*N_ISSUE-1:0]  waddr_wb_i;
    logic [32*N_ISSUE-1:0] wdata_wb_i;
    logic [N_RD-1:0]       rd_valid_i;
    logic [6*N_RD-1:0]     rd_addr_i;
    logic                  cnt_clr_i;
    logic [N_RD-1:0]       fw_hit_o;
    logic [32*N_RD-1:0]    fw_data_o;
    logic [N_RD-1:0]       fw_stall_o;
    logic [CNT_W-1:0]      hit_cnt_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output alu_we_fw_i, alu_waddr_fw_i, alu_wdata_fw_i, ex_ld_pend_i, waddr_ex_i,
               we_wb_i, waddr_wb_i, wdata_wb_i, rd_valid_i, rd_addr_i, cnt_clr_i,
        input  fw_hit_o, fw_data_o, fw_stall_o, hit_cnt_o, stall_cnt_o
    );

    modport slave (
        input  alu_we_fw_i, alu_waddr_fw_i, alu_wdata_fw_i, ex_ld_pend_i, waddr_ex_i,
               we_wb_i, waddr_wb_i, wdata_wb_i, rd_valid_i, rd_addr_i, cnt_clr_i,
        output fw_hit_o, fw_data_o, fw_stall_o, hit_cnt_o, stall_cnt_o
    );
endinterface

// File: rtl/di_xfw_bypass_unit.sv
// Cross-issue register bypass: resolves operand reads against EX, WB and a short WB history,
// youngest source first, and flags load-use hazards.
module di_xfw_bypass_unit #(
    parameter int unsigned N_ISSUE    = 2,
    parameter int unsigned N_RD       = 4,
    parameter int unsigned HIST_DEPTH = 1,
    parameter int unsigned CNT_W      = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    di_xfw_bypass_if.slave      bus
);

    logic [HIST_DEPTH-1:0][N_ISSUE-1:0]        hist_valid_q;
    logic [HIST_DEPTH-1:0][N_ISSUE-1:0][5:0]   hist_addr_q;
    logic [HIST_DEPTH-1:0][N_ISSUE-1:0][31:0]  hist_data_q;

    logic [N_RD-1:0]    fw_hit;
    logic [N_RD-1:0]    fw_stall;
    logic [32*N_RD-1:0] fw_data;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    // Index 0 holds age 1; each cycle everything ages by one and the oldest falls off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid_q <= '0;
            hist_addr_q  <= '0;
            hist_data_q  <= '0;
        end else begin
            for (int k = 1; k < int'(HIST_DEPTH); k++) begin
                hist_valid_q[k] <= hist_valid_q[k-1];
                hist_addr_q[k]  <= hist_addr_q[k-1];
                hist_data_q[k]  <= hist_data_q[k-1];
            end
            for (int i = 0; i < int'(N_ISSUE); i++) begin
                hist_valid_q[0][i] <= bus.we_wb_i[i];
                hist_addr_q[0][i]  <= bus.waddr_wb_i[6*i +: 6];
                hist_data_q[0][i]  <= bus.wdata_wb_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        fw_hit   = '0;
        fw_stall = '0;
        fw_data  = '0;
        for (int p = 0; p < int'(N_RD); p++) begin
            logic       found;
            logic [5:0] a;
            a     = bus.rd_addr_i[6*p +: 6];
            found = !bus.rd_valid_i[p] || (a == 6'd0);
            for (int i = int'(N_ISSUE) - 1; i >= 0; i--) begin
                // Within one issue an ALU result outranks a pending load.
                if (!found && bus.alu_we_fw_i[i] && bus.alu_waddr_fw_i[6*i +: 6] == a) begin
                    found                = 1'b1;
                    fw_hit[p]            = 1'b1;
                    fw_data[32*p +: 32]  = bus.alu_wdata_fw_i[32*i +: 32];
                end else if (!found && bus.ex_ld_pend_i[i] && bus.waddr_ex_i[6*i +: 6] == a) begin
                    found       = 1'b1;
                    fw_stall[p] = 1'b1;
                end
            end
            for (int i = int'(N_ISSUE) - 1; i >= 0; i--) begin
                if (!found && bus.we_wb_i[i] && bus.waddr_wb_i[6*i +: 6] == a) begin
                    found               = 1'b1;
                    fw_hit[p]           = 1'b1;
                    fw_data[32*p +: 32] = bus.wdata_wb_i[32*i +: 32];
                end
            end
            for (int k = 0; k < int'(HIST_DEPTH); k++) begin
                for (int i = int'(N_ISSUE) - 1; i >= 0; i--) begin
                    if (!found && hist_valid_q[k][i] && hist_addr_q[k][i] == a) begin
                        found               = 1'b1;
                        fw_hit[p]           = 1'b1;
                        fw_data[32*p +: 32] = hist_data_q[k][i];
                    end
                end
            end
        end
    end

    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr_i) begin
            hit_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (|fw_hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            if (|fw_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fw_hit_o    = fw_hit;
    assign bus.fw_stall_o  = fw_stall;
    assign bus.fw_data_o   = fw_data;
    assign bus.hit_cnt_o   = hit_cnt_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_di_xfw_bypass_unit.sv
// Bench for di_xfw_bypass_unit: directed scenarios plus random traffic against a
// priority-ranked source-list model.
module tb_di_xfw_bypass_unit;

    localparam int NI = 2;
    localparam int NR = 4;
    localparam int HD = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    di_xfw_bypass_if #(.N_ISSUE(NI), .N_RD(NR), .CNT_W(CW)) bus ();

    di_xfw_bypass_unit #(
        .N_ISSUE(NI), .N_RD(NR), .HIST_DEPTH(HD), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: log of past WB writes tagged with the cycle they were written in.
    typedef struct {
        int          cyc;
        int          iss;
        logic [5:0]  addr;
        logic [31:0] data;
    } wb_ev_t;

    wb_ev_t log_q[$];
    int     cyc = 0;
    int     m_hit_cnt = 0;
    int     m_stall_cnt = 0;

    // Lower rank wins: EX, then WB, then history by age; younger issue first; ALU before load.
    function automatic void model_port(input int p, output logic h, output logic s,
                                       output logic [31:0] d);
        int best;
        int r;
        int age;
        logic [5:0] a;
        best = 1 << 30;
        a = bus.rd_addr_i[6*p +: 6];
        h = 1'b0; s = 1'b0; d = '0;
        if (!bus.rd_valid_i[p] || a == 6'd0) return;
        for (int i = 0; i < NI; i++) begin
            r = 2 * (NI - 1 - i);
            if (bus.alu_we_fw_i[i] && bus.alu_waddr_fw_i[6*i +: 6] == a && r < best) begin
                best = r; h = 1'b1; s = 1'b0; d = bus.alu_wdata_fw_i[32*i +: 32];
            end
            if (bus.ex_ld_pend_i[i] && bus.waddr_ex_i[6*i +: 6] == a && r + 1 < best) begin
                best = r + 1; h = 1'b0; s = 1'b1; d = '0;
            end
            r = 2 * (NI + NI - 1 - i);
            if (bus.we_wb_i[i] && bus.waddr_wb_i[6*i +: 6] == a && r < best) begin
                best = r; h = 1'b1; s = 1'b0; d = bus.wdata_wb_i[32*i +: 32];
            end
        end
        foreach (log_q[j]) begin
            age = cyc - log_q[j].cyc;
            r = 2 * ((1 + age) * NI + NI - 1 - log_q[j].iss);
            if (age >= 1 && age <= HD && log_q[j].addr == a && r < best) begin
                best = r; h = 1'b1; s = 1'b0; d = log_q[j].data;
            end
        end
    endfunction

    task automatic clear_in();
        bus.alu_we_fw_i = '0; bus.alu_waddr_fw_i = '0; bus.alu_wdata_fw_i = '0;
        bus.ex_ld_pend_i = '0; bus.waddr_ex_i = '0;
        bus.we_wb_i = '0; bus.waddr_wb_i = '0; bus.wdata_wb_i = '0;
        bus.rd_valid_i = '0; bus.rd_addr_i = '0; bus.cnt_clr_i = 1'b0;
    endtask

    task automatic set_alu(input int i, input logic [5:0] a, input logic [31:0] d);
        bus.alu_we_fw_i[i] = 1'b1; bus.alu_waddr_fw_i[6*i +: 6] = a;
        bus.alu_wdata_fw_i[32*i +: 32] = d;
    endtask

    task automatic set_ld(input int i, input logic [5:0] a);
        bus.ex_ld_pend_i[i] = 1'b1; bus.waddr_ex_i[6*i +: 6] = a;
    endtask

    task automatic set_wb(input int i, input logic [5:0] a, input logic [31:0] d);
        bus.we_wb_i[i] = 1'b1; bus.waddr_wb_i[6*i +: 6] = a; bus.wdata_wb_i[32*i +: 32] = d;
    endtask

    task automatic set_rd(input int p, input logic [5:0] a);
        bus.rd_valid_i[p] = 1'b1; bus.rd_addr_i[6*p +: 6] = a;
    endtask

    // Called at a negedge with inputs set; checks lookups, clocks once, checks counters.
    task automatic step(input string tag);
        logic h, s, any_h, any_s;
        logic [31:0] d;
        any_h = 1'b0; any_s = 1'b0;
        #1;
        for (int p = 0; p < NR; p++) begin
            model_port(p, h, s, d);
            any_h |= h; any_s |= s;
            check($sformatf("%s.hit%0d", tag, p), bus.fw_hit_o[p], h);
            check($sformatf("%s.stall%0d", tag, p), bus.fw_stall_o[p], s);
            check($sformatf("%s.data%0d", tag, p), bus.fw_data_o[32*p +: 32], d);
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++)
            if (bus.we_wb_i[i])
                log_q.push_back('{cyc, i, bus.waddr_wb_i[6*i +: 6], bus.wdata_wb_i[32*i +: 32]});
        cyc++;
        while (log_q.size() > 0 && cyc - log_q[0].cyc > HD) void'(log_q.pop_front());
        if (bus.cnt_clr_i) begin
            m_hit_cnt = 0; m_stall_cnt = 0;
        end else begin
            if (any_h && m_hit_cnt < CMAX) m_hit_cnt++;
            if (any_s && m_stall_cnt < CMAX) m_stall_cnt++;
        end
        #1;
        check({tag, ".hit_cnt"}, bus.hit_cnt_o, m_hit_cnt);
        check({tag, ".stall_cnt"}, bus.stall_cnt_o, m_stall_cnt);
        @(negedge clk);
    endtask

    logic [5:0] addr_pool [6];

    initial begin
        addr_pool = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd32, 6'd33};
        clear_in();
        repeat (2) @(negedge clk);
        set_rd(0, 6'd5);
        #1;
        check("rst.hit_cnt", bus.hit_cnt_o, 0);
        check("rst.stall_cnt", bus.stall_cnt_o, 0);
        check("rst.hit", bus.fw_hit_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU forwarding from both issues: the younger issue wins.
        clear_in(); set_alu(0, 6'd5, 32'h11); set_alu(1, 6'd5, 32'h22); set_rd(0, 6'd5);
        #1;
        check("alu.hit", bus.fw_hit_o[0], 1'b1);
        check("alu.data", bus.fw_data_o[31:0], 32'h22);
        step("alu");

        // WB history visible for HD cycles then gone.
        clear_in(); set_wb(0, 6'd7, 32'hAB); step("hist_t");
        clear_in(); set_rd(1, 6'd7);
        #1; check("hist.t1", bus.fw_data_o[63:32], 32'hAB); step("hist_t1");
        #1; check("hist.t2", bus.fw_hit_o[1], 1'b1); step("hist_t2");
        #1; check("hist.t3", bus.fw_hit_o[1], 1'b0); step("hist_t3");

        // Load-use, then shadowed by a younger ALU write.
        clear_in(); set_ld(0, 6'd9); set_wb(0, 6'd9, 32'h5); set_rd(2, 6'd9);
        #1;
        check("ld.stall", bus.fw_stall_o[2], 1'b1);
        check("ld.hit", bus.fw_hit_o[2], 1'b0);
        step("ld");
        clear_in(); set_ld(0, 6'd9); set_wb(0, 6'd9, 32'h5); set_alu(1, 6'd9, 32'h7);
        set_rd(2, 6'd9);
        #1;
        check("ldsh.stall", bus.fw_stall_o[2], 1'b0);
        check("ldsh.data", bus.fw_data_o[95:64], 32'h7);
        step("ldsh");

        // x0 never hits, f0 is a normal register.
        clear_in(); set_alu(0, 6'd0, 32'hFF); set_alu(1, 6'd32, 32'hFF);
        set_rd(0, 6'd0); set_rd(3, 6'd32);
        #1;
        check("x0.hit", bus.fw_hit_o[0], 1'b0);
        check("f0.data", bus.fw_data_o[127:96], 32'hFF);
        step("x0f0");

        // Counter saturation and clear-over-increment.
        for (int n = 0; n < 20; n++) begin
            clear_in(); set_alu(0, 6'd1, n); set_rd(0, 6'd1); step("sat");
        end
        check("sat.hit_cnt", bus.hit_cnt_o, CMAX);
        clear_in(); set_alu(0, 6'd1, 32'h1); set_rd(0, 6'd1); bus.cnt_clr_i = 1'b1;
        step("clr");
        check("clr.hit_cnt", bus.hit_cnt_o, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            clear_in();
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 1) == 1) set_alu(i, addr_pool[$urandom_range(0, 5)], $urandom);
                if ($urandom_range(0, 3) == 0) set_ld(i, addr_pool[$urandom_range(0, 5)]);
                if ($urandom_range(0, 1) == 1) set_wb(i, addr_pool[$urandom_range(0, 5)], $urandom);
            end
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 3) != 0) set_rd(p, addr_pool[$urandom_range(0, 5)]);
            bus.cnt_clr_i = ($urandom_range(0, 15) == 0);
            step("rnd");
        end

        // Asynchronous reset mid-run clears counters and history.
        clear_in(); set_wb(0, 6'd3, 32'h33); set_rd(0, 6'd1); set_alu(0, 6'd1, 32'h1);
        step("rst_t");
        clear_in();
        #3 rst_n = 1'b0;
        #1;
        check("arst.hit_cnt", bus.hit_cnt_o, 0);
        check("arst.stall_cnt", bus.stall_cnt_o, 0);
        log_q.delete(); m_hit_cnt = 0; m_stall_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        set_rd(0, 6'd3);
        #1;
        check("arst.x3", bus.fw_hit_o[0], 1'b0);
        step("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
